// File: rtl/fpga_io_pkg.sv
// Shared types, limits and helpers for the board-display info browser.
package fpga_io_pkg;

  typedef enum logic [1:0] {
    SRC_INSTR = 2'd0,
    SRC_REGS  = 2'd1,
    SRC_MEM   = 2'd3
  } info_src_t;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_HOLD,
    RPT_REPEAT
  } rpt_state_t;

  localparam int LIMIT_INSTR = 256;
  localparam int LIMIT_REGS  = 32;
  localparam int LIMIT_MEM   = 1024;

  function automatic logic [10:0] src_limit(info_src_t src);
    case (src)
      SRC_REGS: return 11'(LIMIT_REGS);
      SRC_MEM:  return 11'(LIMIT_MEM);
      default:  return 11'(LIMIT_INSTR);
    endcase
  endfunction

  function automatic info_src_t next_src(info_src_t src);
    case (src)
      SRC_INSTR: return SRC_REGS;
      SRC_REGS:  return SRC_MEM;
      default:   return SRC_INSTR;
    endcase
  endfunction

endpackage

// File: rtl/info_navigator_if.sv
// Board buttons in, chooser select/index out.
interface info_navigator_if;
  logic       btnNext;
  logic       btnPrev;
  logic       btnMode;
  logic [1:0] select;
  logic [9:0] derreference;
  logic       changed;

  modport master (
    output btnNext, btnPrev, btnMode,
    input  select, derreference, changed
  );

  modport slave (
    input  btnNext, btnPrev, btnMode,
    output select, derreference, changed
  );
endinterface

// File: rtl/info_navigator_button_conditioner.sv
// Synchronizes, debounces and edge-detects one raw push-button.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic             level_d;
  logic [CNT_W-1:0] deb_cnt;

  // The level only moves after a full run of disagreeing samples; one agreeing sample restarts the run.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync_a  <= raw;
      sync_b  <= sync_a;
      level_d <= level;
      press   <= level & ~level_d;
      if (sync_b != level) begin
        if (deb_cnt == DEB_LAST) begin
          level   <= sync_b;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= CNT_W'(deb_cnt + 1'b1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/info_navigator.sv
// Button-driven browser producing the select/derreference pair for the info chooser.
module info_navigator
  import fpga_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input logic             clock,
  input logic             reset,
  info_navigator_if.slave nav
);

  localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] HOLD_LAST   = RPT_W'(HOLD_CYCLES - 1);
  localparam logic [RPT_W-1:0] REPEAT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  // Index 0 is Next, index 1 is Prev.
  logic [1:0] step_level;
  logic [1:0] step_press;
  logic       mode_level_unused;
  logic       mode_press;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clock(clock), .reset(reset), .raw(nav.btnNext),
    .level(step_level[0]), .press(step_press[0])
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
    .clock(clock), .reset(reset), .raw(nav.btnPrev),
    .level(step_level[1]), .press(step_press[1])
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clock(clock), .reset(reset), .raw(nav.btnMode),
    .level(mode_level_unused), .press(mode_press)
  );

  rpt_state_t       rpt_state    [2];
  rpt_state_t       rpt_state_nx [2];
  logic [RPT_W-1:0] rpt_cnt      [2];
  logic [RPT_W-1:0] rpt_cnt_nx   [2];
  logic [1:0]       rpt_evt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        rpt_state[i] <= RPT_IDLE;
        rpt_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        rpt_state[i] <= rpt_state_nx[i];
        rpt_cnt[i]   <= rpt_cnt_nx[i];
      end
    end
  end

  // A press starts the hold wait; a release anywhere drops straight back to idle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rpt_state_nx[i] = rpt_state[i];
      rpt_cnt_nx[i]   = rpt_cnt[i];
      rpt_evt[i]      = 1'b0;
      if (!step_level[i]) begin
        rpt_state_nx[i] = RPT_IDLE;
        rpt_cnt_nx[i]   = '0;
      end else if (step_press[i]) begin
        rpt_state_nx[i] = RPT_HOLD;
        rpt_cnt_nx[i]   = '0;
      end else begin
        case (rpt_state[i])
          RPT_HOLD: begin
            if (rpt_cnt[i] == HOLD_LAST) begin
              rpt_evt[i]      = 1'b1;
              rpt_state_nx[i] = RPT_REPEAT;
              rpt_cnt_nx[i]   = '0;
            end else begin
              rpt_cnt_nx[i] = RPT_W'(rpt_cnt[i] + 1'b1);
            end
          end
          RPT_REPEAT: begin
            if (rpt_cnt[i] == REPEAT_LAST) begin
              rpt_evt[i]    = 1'b1;
              rpt_cnt_nx[i] = '0;
            end else begin
              rpt_cnt_nx[i] = RPT_W'(rpt_cnt[i] + 1'b1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic       next_evt;
  logic       prev_evt;
  info_src_t  sel_q;
  info_src_t  sel_nx;
  logic [1:0] sel_raw;
  logic [9:0] d_q;
  logic [9:0] d_nx;
  logic [9:0] limit_last;
  logic       pend_q;
  logic       pend_nx;
  logic       changed_q;

  assign next_evt   = step_press[0] | rpt_evt[0];
  assign prev_evt   = step_press[1] | rpt_evt[1];
  assign sel_raw    = sel_q;
  assign limit_last = 10'(src_limit(sel_q) - 11'd1);

  // Illegal select recovery outranks Mode, which outranks Next/Prev; Next with Prev cancels.
  always_comb begin
    sel_nx = sel_q;
    d_nx   = d_q;
    if (sel_raw == 2'd2) begin
      sel_nx = SRC_INSTR;
      d_nx   = '0;
    end else if (mode_press) begin
      sel_nx = next_src(sel_q);
      d_nx   = '0;
    end else if (next_evt && !prev_evt) begin
      d_nx = (d_q == limit_last) ? 10'd0 : 10'(d_q + 10'd1);
    end else if (prev_evt && !next_evt) begin
      d_nx = (d_q == 10'd0) ? limit_last : 10'(d_q - 10'd1);
    end
    pend_nx = (sel_nx != sel_q) || (d_nx != d_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_q     <= SRC_INSTR;
      d_q       <= '0;
      pend_q    <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      sel_q     <= sel_nx;
      d_q       <= d_nx;
      pend_q    <= pend_nx;
      changed_q <= pend_q;
    end
  end

  assign nav.select       = sel_q;
  assign nav.derreference = d_q;
  assign nav.changed      = changed_q;

endmodule

// File: tb/tb_info_navigator.sv
// Randomized self-checking bench for info_navigator against an event-level model.
module tb_info_navigator;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int RPT  = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   exp_sel = 0;
  int   exp_d = 0;
  int   hist_count = 0;
  logic [11:0] prev_val = '0;
  logic [11:0] prev2_val = '0;

  info_navigator_if nav();

  info_navigator #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(RPT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .nav(nav)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", tag, actual, expected);
    end
  endtask

  function automatic int limitOf(input int s);
    if (s == 1) return 32;
    if (s == 3) return 1024;
    return 256;
  endfunction

  function automatic int nextSrcOf(input int s);
    if (s == 0) return 1;
    if (s == 1) return 3;
    return 0;
  endfunction

  // Event-level model: entries live on a ring of limitOf(select) positions.
  function automatic void modelEvent(input bit nxt, input bit prv, input bit mode);
    if (mode) begin
      exp_sel = nextSrcOf(exp_sel);
      exp_d   = 0;
    end else if (nxt && !prv) begin
      exp_d = (exp_d + 1) % limitOf(exp_sel);
    end else if (prv && !nxt) begin
      exp_d = (exp_d + limitOf(exp_sel) - 1) % limitOf(exp_sel);
    end
  endfunction

  task automatic checkState(input string tag);
    checkOutput({tag, "_select"}, 32'(nav.select), exp_sel);
    checkOutput({tag, "_derref"}, 32'(nav.derreference), exp_d);
  endtask

  // A clean press short enough that auto-repeat never starts.
  task automatic applyStimulus(input bit nxt, input bit prv, input bit mode, input string tag);
    @(negedge clock);
    nav.btnNext = nxt;
    nav.btnPrev = prv;
    nav.btnMode = mode;
    repeat (DEB + 6) @(negedge clock);
    nav.btnNext = 1'b0;
    nav.btnPrev = 1'b0;
    nav.btnMode = 1'b0;
    repeat (DEB + 8) @(negedge clock);
    modelEvent(nxt, prv, mode);
    checkState(tag);
  endtask

  // Count rising edges from a raw change until derreference moves away from 'from'.
  task automatic waitStep(input int from, output int edges, output bit found);
    found = 1'b0;
    edges = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clock);
      #1;
      edges++;
      if (32'(nav.derreference) != from) found = 1'b1;
    end
  endtask

  task automatic holdNext(input int extra, input string tag);
    int  edges;
    int  k_last;
    int  steps;
    bit  found;
    @(negedge clock);
    nav.btnNext = 1'b1;
    waitStep(exp_d, edges, found);
    checkOutput({tag, "_first_step"}, 32'(found), 1);
    repeat (extra) @(negedge clock);
    nav.btnNext = 1'b0;
    // Level stays high for press-relative cycles 0..DEB+extra+1; steps at 0, HOLD, HOLD+RPT, ...
    k_last = DEB + extra + 1;
    steps  = 1 + ((k_last >= HOLD) ? (k_last - HOLD) / RPT + 1 : 0);
    for (int i = 0; i < steps; i++) modelEvent(1'b1, 1'b0, 1'b0);
    repeat (DEB + 8) @(negedge clock);
    checkState(tag);
    repeat (30) @(negedge clock);
    checkState({tag, "_settled"});
  endtask

  // changed must follow every visible value change by exactly one cycle.
  always @(negedge clock) begin
    if (reset) begin
      hist_count = 0;
    end else begin
      if (hist_count >= 2) checkOutput("changed_pulse", 32'(nav.changed), 32'(prev_val != prev2_val));
      checkOutput("select_legal", 32'(nav.select == 2'd2), 0);
      prev2_val = prev_val;
      prev_val  = {nav.select, nav.derreference};
      if (hist_count < 2) hist_count++;
    end
  end

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int  edges;
    int  op;
    bit  found;
    nav.btnNext = 1'b0;
    nav.btnPrev = 1'b0;
    nav.btnMode = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    $display("[TB] idle after reset");
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checkState("idle");
      checkOutput("idle_changed", 32'(nav.changed), 0);
    end

    $display("[TB] glitch and clean press");
    @(negedge clock);
    nav.btnNext = 1'b1;
    repeat (3) @(negedge clock);
    nav.btnNext = 1'b0;
    repeat (12) @(negedge clock);
    checkState("glitch");

    @(negedge clock);
    nav.btnNext = 1'b1;
    waitStep(0, edges, found);
    checkOutput("press_latency", 32'(edges), 2 + DEB + 1 + 1);
    @(posedge clock);
    #1;
    checkOutput("latency_changed_hi", 32'(nav.changed), 1);
    @(posedge clock);
    #1;
    checkOutput("latency_changed_lo", 32'(nav.changed), 0);
    @(negedge clock);
    nav.btnNext = 1'b0;
    repeat (DEB + 8) @(negedge clock);
    modelEvent(1'b1, 1'b0, 1'b0);
    checkState("clean_press");

    $display("[TB] wrap-around");
    applyStimulus(1'b0, 1'b1, 1'b0, "back_to_zero");
    applyStimulus(1'b0, 1'b0, 1'b1, "to_regs");
    applyStimulus(1'b0, 1'b1, 1'b0, "regs_prev_wrap");
    applyStimulus(1'b1, 1'b0, 1'b0, "regs_next_wrap");
    applyStimulus(1'b0, 1'b0, 1'b1, "to_mem");
    applyStimulus(1'b0, 1'b1, 1'b0, "mem_prev_wrap");
    applyStimulus(1'b1, 1'b0, 1'b0, "mem_next_wrap");
    applyStimulus(1'b0, 1'b0, 1'b1, "to_instr");
    applyStimulus(1'b0, 1'b1, 1'b0, "instr_prev_wrap");
    applyStimulus(1'b1, 1'b0, 1'b0, "instr_next_wrap");

    $display("[TB] mode cycling");
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b0, 1'b0, "walk");
    applyStimulus(1'b0, 1'b0, 1'b1, "mode_a");
    applyStimulus(1'b0, 1'b0, 1'b1, "mode_b");
    applyStimulus(1'b0, 1'b0, 1'b1, "mode_c");

    $display("[TB] auto-repeat");
    holdNext(41, "hold_fixed");
    holdNext($urandom_range(5, 60), "hold_random");

    $display("[TB] simultaneous buttons");
    applyStimulus(1'b1, 1'b1, 1'b0, "next_prev");
    applyStimulus(1'b1, 1'b0, 1'b1, "mode_next");

    $display("[TB] random operations");
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 6);
      case (op)
        0, 1:    applyStimulus(1'b1, 1'b0, 1'b0, "rand_next");
        2, 3:    applyStimulus(1'b0, 1'b1, 1'b0, "rand_prev");
        4:       applyStimulus(1'b0, 1'b0, 1'b1, "rand_mode");
        5:       applyStimulus(1'b1, 1'b1, 1'b0, "rand_both");
        default: applyStimulus(1'b0, 1'b1, 1'b1, "rand_mode_prev");
      endcase
    end

    $display("[TB] reset during hold");
    applyStimulus(1'b1, 1'b0, 1'b0, "pre_reset");
    @(negedge clock);
    nav.btnNext = 1'b1;
    waitStep(exp_d, edges, found);
    checkOutput("pre_reset_step", 32'(found), 1);
    repeat (3) @(negedge clock);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    exp_sel = 0;
    exp_d   = 0;
    checkState("async_reset");
    checkOutput("async_reset_changed", 32'(nav.changed), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    waitStep(0, edges, found);
    checkOutput("redebounce_latency", 32'(edges), 2 + DEB + 1 + 1);
    @(negedge clock);
    nav.btnNext = 1'b0;
    repeat (DEB + 8) @(negedge clock);
    modelEvent(1'b1, 1'b0, 1'b0);
    checkState("after_reset_press");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
